branch_pc_sequencer: RTL and testbench



---
 rtl/cpu_isa_pkg.sv | 37 +++
 rtl/branch_cond_eval.sv | 32 +++
 rtl/branch_pc_sequencer.sv | 133 +++++++++++++
 tb/tb_branch_pc_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the control-flow path.
//   - Opcode constants for br / jr / jal.
//   - C2 condition encodings.
//   - Instruction field bit positions.
//   - Sequencer state encoding.
//   - Sign-extension helper for the 19-bit displacement C.
package cpu_isa_pkg;

  localparam logic [4:0] OP_BR  = 5'b10010;
  localparam logic [4:0] OP_JR  = 5'b10011;
  localparam logic [4:0] OP_JAL = 5'b10100;

  localparam logic [1:0] COND_ZR = 2'b00;  // value == 0
  localparam logic [1:0] COND_NZ = 2'b01;  // value != 0
  localparam logic [1:0] COND_PL = 2'b10;  // sign bit clear
  localparam logic [1:0] COND_MI = 2'b11;  // sign bit set

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int C2_MSB  = 20;
  localparam int C2_LSB  = 19;
  localparam int C_MSB   = 18;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_READ   = 3'd1;
  localparam state_t ST_EVAL   = 3'd2;
  localparam state_t ST_UPDATE = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  function automatic logic [31:0] sext_c(input logic [C_MSB:0] c);
    return {{(31 - C_MSB){c[C_MSB]}}, c};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator.
//   c2_i         : C2 condition selector
//   value_i      : register value the condition is tested on
//   force_true_i : unconditional transfer (jr/jal), flag forced to 1
//   flag_o       : condition result
module branch_cond_eval
  import cpu_isa_pkg::*;
(
  input  logic [1:0]  c2_i,
  input  logic [31:0] value_i,
  input  logic        force_true_i,
  output logic        flag_o
);

  always_comb begin
    // NOTE: a default is assigned before any branch so every path drives
    // flag_o; a missing path would otherwise infer a latch.
    flag_o = 1'b0;
    if (force_true_i) begin
      flag_o = 1'b1;
    end else begin
      case (c2_i)
        COND_ZR: flag_o = (value_i == 32'd0);
        COND_NZ: flag_o = (value_i != 32'd0);
        COND_PL: flag_o = ~value_i[31];
        COND_MI: flag_o = value_i[31];
        default: flag_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program-counter owner and control-flow executor (br / jr / jal).
//   clk, reset           : clock, synchronous active-high reset
//   start, ir            : execute request and instruction (captured on accept)
//   fetch_adv            : PC+1 request from fetch, honoured only when idle
//   rd_req/rd_idx/rd_ack/rd_data : register-read handshake for Ra
//   link_we/link_idx/link_data   : link-register write port (jal)
//   pc                   : program counter
//   busy/done/taken/illegal      : status to the control unit
module branch_pc_sequencer
  import cpu_isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  LINK_REG = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        fetch_adv,
  output logic        rd_req,
  output logic [3:0]  rd_idx,
  input  logic        rd_ack,
  input  logic [31:0] rd_data,
  output logic        link_we,
  output logic [3:0]  link_idx,
  output logic [31:0] link_data,
  output logic [31:0] pc,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        illegal
);

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   base_pc_q;   // pc at accept; branch base and link value
  logic [4:0]    opc_q;
  logic [3:0]    ra_q;
  logic [1:0]    c2_q;
  logic [C_MSB:0] c_q;
  logic [31:0]   val_q;       // Ra as read, so jal to LINK_REG uses the old value
  logic          flag_q;
  logic          illegal_q;
  logic          cond_flag;
  logic          accept;
  logic          ir_legal;

  // ir[22:21] carry no meaning for this block.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[22:21];

  assign accept   = (state_q == ST_IDLE) && start;
  assign ir_legal = (ir[OPC_MSB:OPC_LSB] == OP_BR)  ||
                    (ir[OPC_MSB:OPC_LSB] == OP_JR)  ||
                    (ir[OPC_MSB:OPC_LSB] == OP_JAL);

  branch_cond_eval u_cond_eval (
    .c2_i         (c2_q),
    .value_i      (val_q),
    .force_true_i (opc_q != OP_BR),
    .flag_o       (cond_flag)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        // start takes priority; a coincident fetch_adv is dropped.
        if (start) begin
          state_d = ir_legal ? ST_READ : ST_DONE;
        end else if (fetch_adv) begin
          pc_d = pc_q + 32'd1;
        end
      end
      ST_READ:   if (rd_ack) state_d = ST_EVAL;
      ST_EVAL:   state_d = ST_UPDATE;
      ST_UPDATE: begin
        state_d = ST_DONE;
        if (opc_q == OP_BR) begin
          if (flag_q) pc_d = base_pc_q + sext_c(c_q);
        end else begin
          pc_d = val_q;
        end
      end
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      base_pc_q <= RESET_PC;
      opc_q     <= 5'd0;
      ra_q      <= 4'd0;
      c2_q      <= 2'd0;
      c_q       <= '0;
      val_q     <= 32'd0;
      flag_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (accept) begin
        opc_q     <= ir[OPC_MSB:OPC_LSB];
        ra_q      <= ir[RA_MSB:RA_LSB];
        c2_q      <= ir[C2_MSB:C2_LSB];
        c_q       <= ir[C_MSB:0];
        base_pc_q <= pc_q;
        illegal_q <= ~ir_legal;
        flag_q    <= 1'b0;   // illegal path skips EVAL, so taken stays 0
      end
      if ((state_q == ST_READ) && rd_ack) val_q <= rd_data;
      if (state_q == ST_EVAL) flag_q <= cond_flag;
    end
  end

  assign pc        = pc_q;
  assign busy      = (state_q != ST_IDLE);
  assign rd_req    = (state_q == ST_READ);
  assign rd_idx    = ra_q;
  assign link_we   = (state_q == ST_UPDATE) && (opc_q == OP_JAL);
  assign link_idx  = LINK_REG;
  assign link_data = base_pc_q;
  assign done      = (state_q == ST_DONE);
  assign taken     = done && flag_q;
  assign illegal   = done && illegal_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed cases followed by
// randomized instructions, checked against a behavioural model.
module tb_branch_pc_sequencer;

  localparam logic [4:0] OP_BR  = 5'b10010;
  localparam logic [4:0] OP_JR  = 5'b10011;
  localparam logic [4:0] OP_JAL = 5'b10100;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic        fetch_adv;
  logic        rd_req;
  logic [3:0]  rd_idx;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        link_we;
  logic [3:0]  link_idx;
  logic [31:0] link_data;
  logic [31:0] pc;
  logic        busy;
  logic        done;
  logic        taken;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [16];
  logic [31:0] m_pc;

  branch_pc_sequencer #(.RESET_PC(32'h0000_0000), .LINK_REG(4'd15)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .ir        (ir),
    .fetch_adv (fetch_adv),
    .rd_req    (rd_req),
    .rd_idx    (rd_idx),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .link_we   (link_we),
    .link_idx  (link_idx),
    .link_data (link_data),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] make_ir(input logic [4:0] o, input logic [3:0] r,
                                          input logic [1:0] c2, input logic [18:0] c);
    logic [1:0] junk;
    junk = 2'($urandom);
    return {o, r, junk, c2, c};
  endfunction

  // Fetch-side PC increments while idle.
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fetch_adv = 1'b1;
      @(posedge clk);
      #1 fetch_adv = 1'b0;
      m_pc = m_pc + 32'd1;
    end
    @(negedge clk);
    check("pc_after_fetch", pc, m_pc);
  endtask

  // Issue one instruction, play the register file with the given ack delay,
  // and compare the outcome with the architectural model.
  task automatic run_instr(input logic [4:0] opc, input logic [3:0] ra, input logic [1:0] c2,
                           input logic [18:0] c, input int delay, input bit with_fetch,
                           input bit busy_noise);
    bit          legal, exp_taken, done_seen;
    logic [31:0] v, exp_pc;
    int          exp_lat, lat, rd_cnt, link_cnt, cint;
    logic        obs_taken, obs_illegal;
    logic [31:0] obs_pc;

    legal     = (opc == OP_BR) || (opc == OP_JR) || (opc == OP_JAL);
    v         = regs[ra];
    cint      = c[18] ? int'(c) - (1 << 19) : int'(c);
    exp_taken = 1'b0;
    exp_pc    = m_pc;
    exp_lat   = legal ? 4 + delay : 1;
    if (opc == OP_BR) begin
      case (c2)
        2'b00: exp_taken = (v == 32'd0);
        2'b01: exp_taken = (v != 32'd0);
        2'b10: exp_taken = (v <  32'h8000_0000);
        default: exp_taken = (v >= 32'h8000_0000);
      endcase
      if (exp_taken) exp_pc = m_pc + 32'(cint);
    end else if (legal) begin
      exp_taken = 1'b1;
      exp_pc    = v;
    end

    @(negedge clk);
    ir        = make_ir(opc, ra, c2, c);
    start     = 1'b1;
    fetch_adv = with_fetch;
    @(posedge clk);
    #1;
    start     = 1'b0;
    fetch_adv = 1'b0;

    done_seen = 1'b0;
    lat = 0; rd_cnt = 0; link_cnt = 0;
    obs_taken = 1'b0; obs_illegal = 1'b0; obs_pc = 32'd0;
    for (int cyc = 1; cyc <= 40 && !done_seen; cyc++) begin
      @(negedge clk);
      rd_ack = 1'b0;
      if (rd_req) begin
        rd_cnt++;
        if (rd_cnt == 1) check("rd_idx", 32'(rd_idx), 32'(ra));
        if (rd_cnt > delay) begin
          rd_ack  = 1'b1;
          rd_data = regs[rd_idx];
        end else begin
          rd_data = $urandom;
        end
      end
      if (link_we) begin
        link_cnt++;
        check("link_idx", 32'(link_idx), 32'd15);
        check("link_data", link_data, m_pc);
      end
      if (busy_noise) begin
        start     = (cyc == 2);
        fetch_adv = (cyc == 2) || (cyc == 3);
        ir        = $urandom;
      end
      if (done) begin
        done_seen   = 1'b1;
        lat         = cyc;
        obs_taken   = taken;
        obs_illegal = illegal;
        obs_pc      = pc;
      end
    end
    start = 1'b0; fetch_adv = 1'b0; rd_ack = 1'b0;

    check("done_seen", 32'(done_seen), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("taken", 32'(obs_taken), 32'(exp_taken));
    check("illegal", 32'(obs_illegal), 32'(!legal));
    check("pc_at_done", obs_pc, exp_pc);
    check("rd_req_cycles", 32'(rd_cnt), legal ? 32'(delay + 1) : 32'd0);
    check("link_pulses", 32'(link_cnt), (opc == OP_JAL) ? 32'd1 : 32'd0);
    m_pc = exp_pc;

    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
    check("pc_after_done", pc, m_pc);
  endtask

  initial begin
    int done_cnt;
    logic [4:0] opc;
    logic [3:0] ra;
    int k;

    reset = 1'b1; start = 1'b0; fetch_adv = 1'b0; rd_ack = 1'b0;
    ir = 32'd0; rd_data = 32'd0;
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    m_pc = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pc", pc, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_link_we", 32'(link_we), 32'd0);
    check("rst_taken", 32'(taken), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_link_idx", 32'(link_idx), 32'd15);
    reset = 1'b0;

    advance(3);                      // pc = 3
    advance(13);                     // pc = 0x10

    regs[2] = 32'd0;                 // br ZR taken, -4 -> 0x0C
    run_instr(OP_BR, 4'd2, 2'b00, 19'h7FFFC, 0, 1'b0, 1'b0);
    advance(4);                      // back to 0x10
    regs[2] = 32'd5;                 // br ZR not taken
    run_instr(OP_BR, 4'd2, 2'b00, 19'h7FFFC, 0, 1'b0, 1'b0);
    regs[2] = 32'h8000_0000;         // br MI taken, +0x10 -> 0x20
    run_instr(OP_BR, 4'd2, 2'b11, 19'h00010, 0, 1'b0, 1'b0);

    regs[15] = 32'h0000_0100;        // jal through the link register itself
    run_instr(OP_JAL, 4'd15, 2'b00, 19'h0, 0, 1'b0, 1'b0);

    regs[7] = 32'h0000_0400;         // jr with delayed ack and busy noise
    run_instr(OP_JR, 4'd7, 2'b00, 19'h0, 3, 1'b0, 1'b1);

    run_instr(5'b00000, 4'd3, 2'b00, 19'h0, 0, 1'b0, 1'b0);   // illegal

    regs[4] = 32'd1;                 // start + fetch_adv together: no increment
    run_instr(OP_BR, 4'd4, 2'b01, 19'h00008, 0, 1'b1, 1'b0);

    regs[9] = 32'h7FFF_FFFF;         // PL taken, large negative offset
    run_instr(OP_BR, 4'd9, 2'b10, 19'h40000, 1, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 9);
      ra = 4'($urandom);
      if (k < 4)      opc = OP_BR;
      else if (k < 6) opc = OP_JR;
      else if (k < 8) opc = OP_JAL;
      else begin
        opc = 5'($urandom);
        if (opc == OP_BR || opc == OP_JR || opc == OP_JAL) opc = 5'b11111;
      end
      case ($urandom_range(0, 3))
        0:       regs[ra] = 32'd0;
        1:       regs[ra] = 32'h8000_0000 | $urandom;
        default: regs[ra] = $urandom;
      endcase
      run_instr(opc, ra, 2'($urandom), 19'($urandom), $urandom_range(0, 3),
                1'($urandom), 1'($urandom));
      advance($urandom_range(0, 2));
    end

    // Reset in the middle of a read: no done, PC back to reset value.
    regs[6] = 32'hDEAD_0000;
    @(negedge clk);
    ir    = make_ir(OP_JR, 4'd6, 2'b00, 19'h0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("mid_read_rd_req", 32'(rd_req), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    m_pc = 32'd0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_done_count", 32'(done_cnt), 32'd0);
    check("abort_pc", pc, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_req", 32'(rd_req), 32'd0);

    regs[1] = 32'h0000_0040;         // normal operation resumes after abort
    run_instr(OP_JAL, 4'd1, 2'b00, 19'h0, 2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
